mult_div_ctrl: RTL and testbench
================================

# mult_div_ctrl

Sequencing controller for the multi-cycle multiply and divide units in the CPU datapath. It accepts one MULT/MULTU/DIV/DIVU request at a time from the CPU control unit. It latches the operands and drives the matching unit's start pulse, counts that unit's fixed iteration latency, then captures the result into the architectural HI/LO registers it owns. It also services MTHI/MTLO writes, reports busy for pipeline stall, and short-circuits division by zero.

## Interface
- WIDTH, 32, operand/result width
- MULT_CYCLES, 32, iteration cycles of the multiplier after its start pulse
- DIV_CYCLES, 32, iteration cycles of the divider after its start pulse

- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- op_valid  in  1  request present
- op_ready  out  1  controller can accept (high only in IDLE)
- op_code  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- op_a, op_b  in  WIDTH  rs/rt operands (op_b = multiplier/divisor)
- flush  in  1  abort in-flight op
- hi_we, lo_we  in  1  MTHI/MTLO write enables
- wdata  in  WIDTH  MTHI/MTLO data
- unit_a, unit_b  out  WIDTH  registered operands to both units
- unit_signed  out  1  signed mode to units
- mult_start, div_start  out  1  one-cycle start pulses
- mult_hi, mult_lo  in  WIDTH  multiplier product halves
- div_quot, div_rem  in  WIDTH  divider results
- hi, lo  out  WIDTH  architectural HI/LO
- busy  out  1  = !op_ready
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle pulse with done on divide-by-zero

## Operation
- States: IDLE, START, RUN, CAPTURE.
- IDLE: on op_valid, latch op_a/op_b into unit_a/unit_b, op_code into an internal op register, and op_code[0]==0 into unit_signed.
  - If DIV/DIVU with op_b==0: stay in IDLE; next cycle done=1 and div_zero=1, HI/LO unchanged.
  - Otherwise: go to START.
- START: assert mult_start (op_code[1]==0) or div_start (op_code[1]==1) for exactly this cycle. Load the iteration counter with N-1 (N = MULT_CYCLES or DIV_CYCLES). Go to RUN.
- RUN: decrement the counter each cycle. At 0, go to CAPTURE.
- CAPTURE: on the ending edge, write hi<=mult_hi, lo<=mult_lo (multiply) or hi<=div_rem, lo<=div_quot (divide). Go to IDLE and assert done the next cycle.
- flush: in START/RUN/CAPTURE, return to IDLE next edge. No HI/LO update, no done, start pulses deasserted. flush in IDLE is a no-op.
- hi_we/lo_we: honoured only while op_ready=1; ignored while busy.
  - If hi_we and op_valid occur in the same IDLE cycle, both take effect; the op's result later overwrites HI/LO.
- unit_a/unit_b hold their values until the next accept.
- The counter is wide enough for max(MULT_CYCLES, DIV_CYCLES)-1. It never wraps.

## Timing
- Request accepted at edge ending cycle T (op_valid && op_ready).
- Start pulse in T+1; RUN covers T+2..T+N+1; CAPTURE in T+N+2.
- done, new hi/lo and op_ready=1 all appear in T+N+3 (T+35 for N=32).
- A back-to-back request may be accepted in the done cycle.
- Divide-by-zero: done/div_zero in T+1, op_ready stays 1.
- Reset (asynchronous, any state): state=IDLE, counter=0, hi=lo=0, unit_a=unit_b=0, unit_signed=0, all pulses 0, op_ready=1, busy=0.
  - Reset mid-operation discards the op and raises no done.

## Structure
- Package mult_div_pkg holds:
  - op_code enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - controller state enum
  - default cycle constants
- Optional sub-module md_iter_counter: loadable down-counter with a zero flag.
- The multiplier and divider stay external; the bench uses behavioural stubs with fixed latency N.

## Test plan
- MULT op_a=7, op_b=-3 (0xFFFFFFFD) -> mult_start only in T+1; done in T+35; hi=0xFFFFFFFF, lo=0xFFFFFFEB; unit_signed=1.
- DIVU op_a=100, op_b=7 -> div_start in T+1; done in T+35; lo=14, hi=2; unit_signed=0.
- DIV op_a=5, op_b=0 with prior hi=0x11, lo=0x22 -> done=div_zero=1 in T+1; no start pulse; hi/lo unchanged.
- MULTU 3×4 with flush in T+10 -> op_ready=1 in T+11; no done; hi/lo keep old values; next request completes normally.
- hi_we=1, wdata=0xABCD in T+5 while busy -> ignored. The same write in IDLE -> hi=0xABCD next cycle, lo untouched.
- reset_n low in T+20 of DIV -> all outputs at reset values immediately. After release, no done; op_ready=1.

Source files
------------

// File: rtl/mult_div_ctrl_pkg.sv
// Shared types and defaults for the multiply/divide sequencing controller.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_CAPTURE
  } ctrl_state_e;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 32;
  localparam int DEF_DIV_CYCLES  = 32;

  // Bits needed to hold max(a,b)-1, never less than one.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// CPU-side request, MTHI/MTLO and HI/LO result bundle of the mult/div controller.
interface mult_div_ctrl_if #(
  parameter int WIDTH = 32
) ();
  import mult_div_pkg::*;

  logic             op_valid;
  logic             op_ready;
  op_code_e         op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output op_valid, op_code, op_a, op_b, flush, hi_we, lo_we, wdata,
    input  op_ready, hi, lo, busy, done, div_zero
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, flush, hi_we, lo_we, wdata,
    output op_ready, hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_ctrl_iter_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, holds at zero.
// Zero flag is combinational from the registered count.
module md_iter_counter #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/mult_div_ctrl.sv
// Sequences one MULT/MULTU/DIV/DIVU at a time: accept, start pulse, N-cycle wait, HI/LO capture; done N+3 cycles after accept.
// op_ready only in IDLE (busy stalls the pipe); divide-by-zero completes next cycle without leaving IDLE.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clock,
  input  logic             reset_n,
  mult_div_ctrl_if.slave   req,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             unit_signed,
  output logic             mult_start,
  output logic             div_start,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem
);
  localparam int           CW        = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  ctrl_state_e      state, state_nxt;
  op_code_e         op_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, div_zero_q;
  logic             accept, zero_div;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]    cnt_val;

  assign req.op_ready = (state == ST_IDLE);
  assign req.busy     = !req.op_ready;
  assign req.hi       = hi_q;
  assign req.lo       = lo_q;
  assign req.done     = done_q;
  assign req.div_zero = div_zero_q;

  assign accept   = req.op_valid && req.op_ready;
  assign zero_div = accept && req.op_code[1] && (req.op_b == '0);
  assign cnt_val  = op_q[1] ? DIV_LOAD : MULT_LOAD;

  md_iter_counter #(.W(CW)) u_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    mult_start = 1'b0;
    div_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && !zero_div) state_nxt = ST_START;
      end
      ST_START: begin
        if (req.flush) begin
          state_nxt = ST_IDLE;
        end else begin
          mult_start = !op_q[1];
          div_start  = op_q[1];
          cnt_load   = 1'b1;
          state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (req.flush)     state_nxt = ST_IDLE;
        else if (cnt_zero) state_nxt = ST_CAPTURE;
        else               cnt_dec   = 1'b1;
      end
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Pulses default low each cycle; capture and MTHI/MTLO are mutually exclusive by state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      unit_a      <= '0;
      unit_b      <= '0;
      unit_signed <= 1'b0;
      op_q        <= OP_MULT;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      if (accept) begin
        unit_a      <= req.op_a;
        unit_b      <= req.op_b;
        op_q        <= req.op_code;
        unit_signed <= !req.op_code[0];
        if (zero_div) begin
          done_q     <= 1'b1;
          div_zero_q <= 1'b1;
        end
      end
      if ((state == ST_CAPTURE) && !req.flush) begin
        done_q <= 1'b1;
        if (op_q[1]) begin
          hi_q <= div_rem;
          lo_q <= div_quot;
        end else begin
          hi_q <= mult_hi;
          lo_q <= mult_lo;
        end
      end else if (req.op_ready) begin
        if (req.hi_we) hi_q <= req.wdata;
        if (req.lo_we) lo_q <= req.wdata;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed plus random checks of mult_div_ctrl against fixed-latency unit stubs and an arithmetic HI/LO model.
module tb_mult_div_ctrl;
  import mult_div_pkg::*;

  localparam int W  = 32;
  localparam int MC = 32;
  localparam int DC = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] unit_a, unit_b, mult_hi, mult_lo, div_quot, div_rem;
  logic         unit_signed, mult_start, div_start;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  mult_div_ctrl_if #(.WIDTH(W)) bus ();

  mult_div_ctrl #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (bus),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_signed (unit_signed),
    .mult_start  (mult_start),
    .div_start   (div_start),
    .mult_hi     (mult_hi),
    .mult_lo     (mult_lo),
    .div_quot    (div_quot),
    .div_rem     (div_rem)
  );

  always #5 clock = ~clock;

  // Architectural result {HI,LO} for an instruction, straight from the ISA definition.
  function automatic logic [63:0] ref_result(input op_code_e code, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (code)
      OP_MULT:  p = 64'(sa * sb);
      OP_MULTU: p = 64'(ua * ub);
      OP_DIV: begin
        q = (b == 0) ? 64'd0 : 64'(sa / sb);
        r = (b == 0) ? 64'd0 : 64'(sa % sb);
        p = {r[31:0], q[31:0]};
      end
      default: begin
        q = (b == 0) ? 64'd0 : 64'(ua / ub);
        r = (b == 0) ? 64'd0 : 64'(ua % ub);
        p = {r[31:0], q[31:0]};
      end
    endcase
    return p;
  endfunction

  // Unit stubs: garbage until exactly N edges after the start pulse.
  int          m_cnt = 0, d_cnt = 0;
  logic [63:0] m_res, d_res;
  always @(posedge clock) begin
    if (mult_start) begin
      m_cnt <= MC;
      m_res <= ref_result(op_code_e'({1'b0, !unit_signed}), unit_a, unit_b);
      {mult_hi, mult_lo} <= 64'hBAD0_BAD1_BAD2_BAD3;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) {mult_hi, mult_lo} <= m_res;
    end
    if (div_start) begin
      d_cnt <= DC;
      d_res <= ref_result(op_code_e'({1'b1, !unit_signed}), unit_a, unit_b);
      {div_rem, div_quot} <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (d_cnt != 0) begin
      d_cnt <= d_cnt - 1;
      if (d_cnt == 1) {div_rem, div_quot} <= d_res;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge; issues one op and follows it cycle by cycle.
  task automatic do_op(input op_code_e code, input logic [31:0] a, input logic [31:0] b,
                       input int flush_cyc, input int hiwe_cyc, input bit idle_wr);
    int n, cyc, stop_cyc, exp_done, exp_ready;
    int done_cyc, dz_cyc, ms_first, ds_first, ms_cnt, ds_cnt, ready_at;
    bit is_div, zero;
    logic [31:0] wd;
    is_div    = code[1];
    zero      = is_div && (b == 0);
    n         = is_div ? DC : MC;
    exp_done  = zero ? 1 : ((flush_cyc > 0) ? 0 : n + 3);
    exp_ready = zero ? 1 : ((flush_cyc > 0) ? flush_cyc + 1 : n + 3);
    stop_cyc  = zero ? 1 : ((flush_cyc > 0) ? flush_cyc + 3 : n + 3);
    wd        = $urandom;
    chk("accept_ready", bus.op_ready, 1);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.hi_we    = idle_wr;
    bus.lo_we    = idle_wr;
    bus.wdata    = wd;
    if (idle_wr) begin
      model_hi = wd;
      model_lo = wd;
    end
    cyc = 0; done_cyc = 0; dz_cyc = 0; ms_first = 0; ds_first = 0;
    ms_cnt = 0; ds_cnt = 0; ready_at = 0;
    while (cyc < stop_cyc && done_cyc == 0 && cyc < n + 10) begin
      @(negedge clock);
      cyc++;
      if (mult_start) begin ms_cnt++; if (ms_first == 0) ms_first = cyc; end
      if (div_start)  begin ds_cnt++; if (ds_first == 0) ds_first = cyc; end
      if (bus.done && done_cyc == 0) done_cyc = cyc;
      if (bus.div_zero && dz_cyc == 0) dz_cyc = cyc;
      if (bus.op_ready && ready_at == 0) ready_at = cyc;
      bus.op_valid = 1'b0;
      bus.lo_we    = 1'b0;
      bus.hi_we    = (cyc == hiwe_cyc);
      bus.flush    = (cyc == flush_cyc);
      if (cyc == hiwe_cyc) bus.wdata = 32'hABCD;
    end
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    if (!zero && flush_cyc == 0) {model_hi, model_lo} = ref_result(code, a, b);
    chk("start_cycle", is_div ? ds_first : ms_first, zero ? 0 : 1);
    chk("start_count", is_div ? ds_cnt : ms_cnt, zero ? 0 : 1);
    chk("other_start", is_div ? ms_cnt : ds_cnt, 0);
    chk("done_cycle", done_cyc, exp_done);
    chk("div_zero_cycle", dz_cyc, zero ? 1 : 0);
    chk("ready_cycle", ready_at, exp_ready);
    chk("unit_signed", unit_signed, !code[0]);
    chk("unit_a", unit_a, a);
    chk("unit_b", unit_b, b);
    chk("hi", bus.hi, model_hi);
    chk("lo", bus.lo, model_lo);
  endtask

  initial begin
    int done_seen;
    logic [31:0] ra, rb;
    bus.op_valid = 1'b0; bus.op_code = OP_MULT; bus.op_a = '0; bus.op_b = '0;
    bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_ready", bus.op_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_units", {unit_a, unit_b}, 64'd0);
    chk("rst_pulses", {unit_signed, mult_start, div_start, bus.done, bus.div_zero}, 5'd0);
    reset_n = 1'b1;
    @(negedge clock);

    do_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 0, 0, 1'b0);
    chk("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", bus.lo, 32'hFFFF_FFEB);

    do_op(OP_DIVU, 32'd100, 32'd7, 0, 0, 1'b0);
    chk("divu_hi_const", bus.hi, 32'd2);
    chk("divu_lo_const", bus.lo, 32'd14);

    bus.hi_we = 1'b1; bus.wdata = 32'h11;
    @(negedge clock);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h22;
    @(negedge clock);
    bus.lo_we = 1'b0;
    model_hi = 32'h11; model_lo = 32'h22;
    chk("mthi_mtlo", {bus.hi, bus.lo}, {32'h11, 32'h22});

    do_op(OP_DIV, 32'd5, 32'd0, 0, 0, 1'b0);
    chk("dz_hilo_kept", {bus.hi, bus.lo}, {32'h11, 32'h22});

    // Flush mid-RUN with a busy-time MTHI attempt; both must leave HI/LO alone.
    do_op(OP_MULTU, 32'd3, 32'd4, 10, 5, 1'b0);
    chk("flush_hilo_kept", {bus.hi, bus.lo}, {32'h11, 32'h22});
    do_op(OP_MULTU, 32'd3, 32'd4, 0, 0, 1'b0);
    chk("multu_after_flush", {bus.hi, bus.lo}, 64'd12);

    bus.hi_we = 1'b1; bus.wdata = 32'hABCD;
    @(negedge clock);
    bus.hi_we = 1'b0;
    model_hi = 32'hABCD;
    chk("idle_mthi", {bus.hi, bus.lo}, {32'hABCD, 32'd12});

    // Asynchronous reset in the middle of a divide.
    bus.op_valid = 1'b1; bus.op_code = OP_DIV; bus.op_a = 32'd1000; bus.op_b = 32'd3;
    @(negedge clock);
    bus.op_valid = 1'b0;
    repeat (19) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("arst_ready", {bus.op_ready, bus.busy}, 2'b10);
    chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("arst_units", {unit_a, unit_b, unit_signed}, 65'd0);
    chk("arst_pulses", {mult_start, div_start, bus.done, bus.div_zero}, 4'd0);
    model_hi = '0; model_lo = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    done_seen = 0;
    repeat (DC + 6) begin
      @(negedge clock);
      if (bus.done) done_seen++;
    end
    chk("arst_no_done", done_seen, 0);
    chk("arst_ready_after", bus.op_ready, 1);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 20));
      do_op(op_code_e'($urandom_range(0, 3)), ra, rb,
            ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 30)) : 0,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 9)) : 0,
            bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
